// File: rtl/shift_seq_unit.sv
// shift_seq_unit: iterative shift/rotate engine for the ALU slot.
// Moves at most STEP bit positions per clock. A start/busy/done handshake
// lets the sequencer hold its T-state until the result is ready. The result,
// carry-out and illegal-opcode flag are held until the next accepted start.
module shift_seq_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             illegal
);

    localparam int AMT_W = $clog2(WIDTH);

    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ROR  = 5'b01100;
    localparam logic [4:0] OP_ROL  = 5'b01101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [AMT_W-1:0] rem;
    logic [4:0]       op;

    logic [AMT_W-1:0] amt_in;
    logic             op_ok;
    logic [AMT_W-1:0] k;
    logic [WIDTH:0]   step_out;

    function automatic logic legal_op(input logic [4:0] o);
        return (o == OP_SHR) || (o == OP_SHRA) || (o == OP_SHL) ||
               (o == OP_ROR) || (o == OP_ROL);
    endfunction

    // One partial shift by k (1..WIDTH-1); returns {carry_out, new_value}.
    // The complementary distance WIDTH-k is simply -k in AMT_W bits.
    function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] w,
                                                  input logic [4:0]       o,
                                                  input logic [AMT_W-1:0] kk);
        logic signed [WIDTH-1:0] sw;
        logic [WIDTH-1:0]        nv;
        logic                    c;
        logic [AMT_W-1:0]        lo_idx;
        logic [AMT_W-1:0]        wrap;
        sw     = w;
        lo_idx = kk - AMT_W'(1);
        wrap   = ~kk + AMT_W'(1);
        nv     = w;
        c      = 1'b0;
        case (o)
            OP_SHR:  begin nv = w >> kk;               c = w[lo_idx];    end
            OP_SHRA: begin nv = sw >>> kk;             c = w[lo_idx];    end
            OP_SHL:  begin nv = w << kk;               c = w[wrap];      end
            OP_ROR:  begin nv = (w >> kk) | (w << wrap); c = nv[WIDTH-1]; end
            OP_ROL:  begin nv = (w << kk) | (w >> wrap); c = nv[0];       end
            default: begin nv = w;                     c = 1'b0;         end
        endcase
        return {c, nv};
    endfunction

    assign amt_in = amount[AMT_W-1:0];
    assign op_ok  = legal_op(opcode);

    // Per-cycle distance: min(rem, STEP), compared one bit wider so STEP == WIDTH fits.
    always_comb begin
        k = rem;
        if ({1'b0, rem} >= (AMT_W+1)'(STEP)) begin
            k = AMT_W'(STEP);
        end
        step_out = shift_step(work, op, k);
    end

    // Control FSM with registered busy/done; clear aborts any operation in progress.
    always_ff @(posedge clock) begin
        if (clear) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            work    <= '0;
            rem     <= '0;
            op      <= '0;
            cout    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        work    <= operand;
                        rem     <= amt_in;
                        op      <= opcode;
                        cout    <= 1'b0;
                        illegal <= ~op_ok;
                        if (!op_ok || amt_in == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                SHIFT: begin
                    {cout, work} <= step_out;
                    rem          <= rem - k;
                    if (rem == k) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign result = work;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Testbench for shift_seq_unit: a WIDTH=32/STEP=4 instance and a
// WIDTH=16/STEP=1 instance share one stimulus stream. Expected results are
// pushed to per-instance queues at each accept and popped on done.
module tb_shift_seq_unit;

    localparam logic [4:0] SHR  = 5'b01001;
    localparam logic [4:0] SHRA = 5'b01010;
    localparam logic [4:0] SHL  = 5'b01011;
    localparam logic [4:0] ROR  = 5'b01100;
    localparam logic [4:0] ROL  = 5'b01101;
    localparam logic [4:0] BAD  = 5'b11111;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  opcode = '0;
    logic [31:0] operand = '0;
    logic [31:0] amount = '0;

    logic        busy32, done32, cout32, ill32;
    logic [31:0] res32;
    logic        busy16, done16, cout16, ill16;
    logic [15:0] res16;

    always #5 clk = ~clk;

    shift_seq_unit #(.WIDTH(32), .STEP(4)) u32 (
        .clock(clk), .clear(clear), .start(start), .opcode(opcode),
        .operand(operand), .amount(amount),
        .busy(busy32), .done(done32), .result(res32), .cout(cout32), .illegal(ill32)
    );

    shift_seq_unit #(.WIDTH(16), .STEP(1)) u16 (
        .clock(clk), .clear(clear), .start(start), .opcode(opcode),
        .operand(operand[15:0]), .amount(amount[15:0]),
        .busy(busy16), .done(done16), .result(res16), .cout(cout16), .illegal(ill16)
    );

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   b32 = 0;
    int   b16 = 0;

    // Reference: one whole shift by n, with latency ceil(n/step).
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] v_in,
                                   input logic [31:0] amt, input int w, input int step,
                                   input int acc);
        exp_t        e;
        logic [63:0] mask, v, r;
        int          n;
        mask  = (64'd1 << w) - 64'd1;
        v     = {32'd0, v_in} & mask;
        n     = int'(amt % 32'(w));
        r     = v;
        e.acc = acc;
        e.ill = 1'b0;
        e.c   = 1'b0;
        e.lat = 0;
        if (!(op inside {SHR, SHRA, SHL, ROR, ROL})) begin
            e.ill = 1'b1;
        end else if (n != 0) begin
            e.lat = (n + step - 1) / step;
            case (op)
                SHR:  begin r = v >> n; e.c = v[n-1]; end
                SHRA: begin r = (v >> n) | (v[w-1] ? (mask & ~(mask >> n)) : 64'd0); e.c = v[n-1]; end
                SHL:  begin r = (v << n) & mask; e.c = v[w-n]; end
                ROR:  begin r = ((v >> n) | (v << (w-n))) & mask; e.c = r[w-1]; end
                default: begin r = ((v << n) | (v >> (w-n))) & mask; e.c = r[0]; end
            endcase
        end
        e.res = r[31:0];
        return e;
    endfunction

    // Drive a request and record what each instance must return for it.
    task automatic apply(input logic [4:0] op, input logic [31:0] v, input logic [31:0] a);
        opcode  = op;
        operand = v;
        amount  = a;
        start   = 1'b1;
        q32.push_back(model(op, v, a, 32, 4, cyc));
        q16.push_back(model(op, v, a, 16, 1, cyc));
    endtask

    // Advance one clock; on done, pop the scoreboard and compare.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (busy32 === 1'b1) b32++;
        if (busy16 === 1'b1) b16++;
        if (done32 === 1'b1) begin
            vectors++;
            if (q32.size() == 0) begin
                miscompares++;
                $display("FAIL u32_unexpected_done cycle=%0d got done=1 want done=0", cyc);
            end else begin
                e = q32.pop_front();
                if (res32 !== e.res || cout32 !== e.c || ill32 !== e.ill) begin
                    miscompares++;
                    $display("FAIL u32_result got %h/c%b/i%b want %h/c%b/i%b",
                             res32, cout32, ill32, e.res, e.c, e.ill);
                end
                vectors++;
                if (cyc != e.acc + 1 + e.lat || b32 != e.lat) begin
                    miscompares++;
                    $display("FAIL u32_latency got lat=%0d busy=%0d want lat=%0d busy=%0d",
                             cyc - e.acc - 1, b32, e.lat, e.lat);
                end
            end
            b32 = 0;
        end
        if (done16 === 1'b1) begin
            vectors++;
            if (q16.size() == 0) begin
                miscompares++;
                $display("FAIL u16_unexpected_done cycle=%0d got done=1 want done=0", cyc);
            end else begin
                e = q16.pop_front();
                if ({16'd0, res16} !== e.res || cout16 !== e.c || ill16 !== e.ill) begin
                    miscompares++;
                    $display("FAIL u16_result got %h/c%b/i%b want %h/c%b/i%b",
                             res16, cout16, ill16, e.res[15:0], e.c, e.ill);
                end
                vectors++;
                if (cyc != e.acc + 1 + e.lat || b16 != e.lat) begin
                    miscompares++;
                    $display("FAIL u16_latency got lat=%0d busy=%0d want lat=%0d busy=%0d",
                             cyc - e.acc - 1, b16, e.lat, e.lat);
                end
            end
            b16 = 0;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (q32.size() == 0 && q16.size() == 0) break;
            tick();
        end
        vectors++;
        if (q32.size() != 0 || q16.size() != 0) begin
            miscompares++;
            $display("FAIL done_timeout got pending=%0d/%0d want 0/0", q32.size(), q16.size());
            q32.delete();
            q16.delete();
        end
    endtask

    task automatic run(input logic [4:0] op, input logic [31:0] v, input logic [31:0] a);
        apply(op, v, a);
        tick();
        start = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset();
        clear = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        vectors++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || res32 !== 32'd0 || cout32 !== 1'b0 || ill32 !== 1'b0 ||
            busy16 !== 1'b0 || done16 !== 1'b0 || res16 !== 16'd0 || cout16 !== 1'b0 || ill16 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset got b%b d%b r%h c%b i%b / b%b d%b r%h c%b i%b want all zero",
                     busy32, done32, res32, cout32, ill32, busy16, done16, res16, cout16, ill16);
        end
        tick();
    endtask

    task automatic test_shl();
        run(SHL, 32'h0000_0022, 32'd4);
        vectors++;
        if (res32 !== 32'h0000_0220 || cout32 !== 1'b0) begin
            miscompares++;
            $display("FAIL shl_quick got %h c%b want 00000220 c0", res32, cout32);
        end
    endtask

    task automatic test_shr_shra();
        run(SHR, 32'hF000_0022, 32'd4);
        vectors++;
        if (res32 !== 32'h0F00_0002) begin
            miscompares++;
            $display("FAIL shr got %h want 0f000002", res32);
        end
        run(SHRA, 32'hF000_0022, 32'd4);
        vectors++;
        if (res32 !== 32'hFF00_0002) begin
            miscompares++;
            $display("FAIL shra got %h want ff000002", res32);
        end
        run(SHRA, 32'h8000_8001, 32'd9);
        run(SHR, 32'h0000_0100, 32'd9);
    endtask

    task automatic test_rotates();
        run(ROR, 32'hF000_0022, 32'd8);
        vectors++;
        if (res32 !== 32'h22F0_0000 || cout32 !== 1'b0) begin
            miscompares++;
            $display("FAIL ror got %h c%b want 22f00000 c0", res32, cout32);
        end
        run(ROL, 32'h8000_0001, 32'd1);
        vectors++;
        if (res32 !== 32'h0000_0003 || cout32 !== 1'b1) begin
            miscompares++;
            $display("FAIL rol got %h c%b want 00000003 c1", res32, cout32);
        end
        run(ROR, 32'h1234_5679, 32'd13);
        run(ROL, 32'hC000_1234, 32'd7);
    endtask

    task automatic test_latency_modulo();
        run(SHL, 32'h0000_0001, 32'd31);
        vectors++;
        if (res32 !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL shl31 got %h want 80000000", res32);
        end
        run(SHR, 32'h0000_0006, 32'd33);
        vectors++;
        if (res32 !== 32'h0000_0003) begin
            miscompares++;
            $display("FAIL modulo33 got %h want 00000003", res32);
        end
        run(SHL, 32'hDEAD_BEEF, 32'd0);
        vectors++;
        if (res32 !== 32'hDEAD_BEEF || res16 !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL amount0 got %h/%h want deadbeef/beef", res32, res16);
        end
        run(SHRA, 32'h8765_4321, 32'd5);
    endtask

    task automatic test_illegal_busy();
        run(BAD, 32'h1234_5678, 32'd5);
        vectors++;
        if (ill32 !== 1'b1 || res32 !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL illegal got i%b %h want i1 12345678", ill32, res32);
        end
        apply(SHR, 32'hF000_0022, 32'd31);
        tick();
        start = 1'b0;
        tick();
        vectors++;
        if (busy32 !== 1'b1 || busy16 !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_mid got %b/%b want 1/1", busy32, busy16);
        end
        opcode  = ROL;
        operand = 32'hFFFF_FFFF;
        amount  = 32'd3;
        start   = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        apply(SHL, 32'hCAFE_0001, 32'd0);
        tick();
        apply(BAD, 32'h0BAD_F00D, 32'd2);
        tick();
        apply(SHR, 32'h0000_00F0, 32'd4);
        tick();
        start = 1'b0;
        wait_idle();
        vectors++;
        if (res32 !== 32'h0000_000F || ill32 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_last got %h i%b want 0000000f i0", res32, ill32);
        end
    endtask

    task automatic test_clear_mid();
        apply(SHL, 32'h0000_0001, 32'd31);
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        vectors++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || res32 !== 32'd0 || cout32 !== 1'b0 ||
            busy16 !== 1'b0 || done16 !== 1'b0 || res16 !== 16'd0 || cout16 !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_mid got b%b d%b r%h / b%b d%b r%h want zeros",
                     busy32, done32, res32, busy16, done16, res16);
        end
        q32.delete();
        q16.delete();
        b32 = 0;
        b16 = 0;
        tick();
        tick();
        run(ROL, 32'h8000_0001, 32'd1);
    endtask

    initial begin
        test_reset();
        test_shl();
        test_shr_shra();
        test_rotates();
        test_latency_modulo();
        test_illegal_busy();
        test_back_to_back();
        test_clear_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
